// File: rtl/common_pkg.sv
// Shared I/O bus types and the standard Z80 port decode constants.
package common;

  typedef logic [15:0] io_addr_t;
  typedef logic [7:0]  io_byte_t;

  // match: address compare value; mask: address bits that take part in the compare
  typedef struct packed {
    io_addr_t match;
    io_addr_t mask;
  } io_decode_t;

  localparam io_decode_t PORT_FE   = '{match: 16'h00FE, mask: 16'h0001};
  localparam io_decode_t PORT_7FFD = '{match: 16'h7FFD, mask: 16'h8002};
  localparam io_decode_t PORT_1FFD = '{match: 16'h1FFD, mask: 16'hFFFF};
  localparam io_decode_t PORT_DFFD = '{match: 16'hDFFD, mask: 16'hFFFF};

endpackage

// File: rtl/cpu_bus.sv
// CPU-side I/O bus bundle: request strobes, latched address and write data.
interface cpu_bus;
  import common::*;

  logic     ioreq;
  logic     rd;
  logic     wr;
  io_addr_t a_reg;
  io_byte_t d_reg;

  modport master (output ioreq, rd, wr, a_reg, d_reg);
  modport slave  (input  ioreq, rd, wr, a_reg, d_reg);
endinterface

// File: rtl/io_port_channel.sv
// One address-decoded 8-bit write port: one commit per bus write cycle,
// optional clkcpu_ck alignment, lock gating and a registered read-select flag.
module io_port_channel #(
  parameter logic [15:0] MATCH    = 16'h0000,
  parameter logic [15:0] MASK     = 16'h0000,
  parameter logic        SYNC     = 1'b0,
  parameter logic        RD_EN    = 1'b0,
  parameter logic        LOCKABLE = 1'b0,
  parameter logic [7:0]  RST_VAL  = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ioreq,
  input  logic        rd,
  input  logic        wr,
  input  logic [15:0] a_reg,
  input  logic [7:0]  d_reg,
  input  logic        clkcpu_ck,
  input  logic        en,
  input  logic        lock_active,
  output logic [7:0]  q,
  output logic        wstb,
  output logic        rd_act
);

  logic       cs;
  logic       ok;
  logic [7:0] q_d, q_q;
  logic       wstb_d, wstb_q;
  logic       done_d, done_q;
  logic       rd_act_d, rd_act_q;

  always_comb begin
    cs       = en & ioreq & (((a_reg ^ MATCH) & MASK) == 16'h0000);
    ok       = cs & wr & ~(LOCKABLE & lock_active) & ~done_q & (~SYNC | clkcpu_ck);
    q_d      = ok ? d_reg : q_q;
    wstb_d   = ok;
    // done holds for the rest of the write cycle so a long wr commits once
    done_d   = cs & wr & (done_q | ok);
    rd_act_d = cs & rd & RD_EN;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q      <= RST_VAL;
      wstb_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_act_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      wstb_q   <= wstb_d;
      done_q   <= done_d;
      rd_act_q <= rd_act_d;
    end
  end

  assign q      = q_q;
  assign wstb   = wstb_q;
  assign rd_act = rd_act_q;

endmodule

// File: rtl/io_port_bank.sv
// Parametrised bank of I/O write ports with a shared lock and a priority read mux.
// Optional IO_READBACK_EN adds RB_MASK: selected channels read back their own register.
module io_port_bank
  import common::*;
#(
  parameter int                     N_PORTS    = 4,
  parameter logic [N_PORTS*16-1:0]  ADDR_MATCH = {PORT_DFFD.match, PORT_1FFD.match,
                                                  PORT_7FFD.match, PORT_FE.match},
  parameter logic [N_PORTS*16-1:0]  ADDR_MASK  = {PORT_DFFD.mask, PORT_1FFD.mask,
                                                  PORT_7FFD.mask, PORT_FE.mask},
  parameter logic [N_PORTS-1:0]     SYNC_MASK  = 4'b0001,
  parameter logic [N_PORTS-1:0]     RD_MASK    = 4'b0001,
  parameter int                     LOCK_SRC   = 1,
  parameter int                     LOCK_BIT   = 5,
  parameter logic [N_PORTS-1:0]     LOCK_MASK  = 4'b0010,
  parameter logic [N_PORTS*8-1:0]   RESET_VAL  = '0
`ifdef IO_READBACK_EN
  ,
  parameter logic [N_PORTS-1:0]     RB_MASK    = '0
`endif
) (
  input  logic                   clk28,
  input  logic                   rst_n,
  cpu_bus.slave                  bus,
  input  logic                   clkcpu_ck,
  input  logic [N_PORTS-1:0]     en,
  input  logic                   unlock,
  input  logic [N_PORTS*8-1:0]   rd_src,
  output logic [N_PORTS*8-1:0]   port_q,
  output logic [N_PORTS-1:0]     wstb,
  output logic                   locked,
  output logic [7:0]             d_out,
  output logic                   d_out_active
);

  logic                 lock_active;
  logic [N_PORTS-1:0]   rd_act;
  logic [N_PORTS*8-1:0] rd_data;

  // Lock comes from the registered value, so a self-write sees the old lock
  assign locked      = port_q[LOCK_SRC*8 + LOCK_BIT];
  assign lock_active = locked & ~unlock;

  for (genvar i = 0; i < N_PORTS; i++) begin : g_ch
    io_port_channel #(
      .MATCH    (ADDR_MATCH[i*16 +: 16]),
      .MASK     (ADDR_MASK[i*16 +: 16]),
      .SYNC     (SYNC_MASK[i]),
      .RD_EN    (RD_MASK[i]),
      .LOCKABLE (LOCK_MASK[i]),
      .RST_VAL  (RESET_VAL[i*8 +: 8])
    ) u_ch (
      .clk         (clk28),
      .rst_n       (rst_n),
      .ioreq       (bus.ioreq),
      .rd          (bus.rd),
      .wr          (bus.wr),
      .a_reg       (bus.a_reg),
      .d_reg       (bus.d_reg),
      .clkcpu_ck   (clkcpu_ck),
      .en          (en[i]),
      .lock_active (lock_active),
      .q           (port_q[i*8 +: 8]),
      .wstb        (wstb[i]),
      .rd_act      (rd_act[i])
    );
  end

`ifdef IO_READBACK_EN
  always_comb begin
    rd_data = rd_src;
    for (int i = 0; i < N_PORTS; i++) begin
      if (RB_MASK[i] & RD_MASK[i]) rd_data[i*8 +: 8] = port_q[i*8 +: 8];
    end
  end
`else
  assign rd_data = rd_src;
`endif

  // Walk from the top down so the lowest active index wins
  always_comb begin
    d_out = 8'hFF;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if (rd_act[i]) d_out = rd_data[i*8 +: 8];
    end
  end

  assign d_out_active = |rd_act;

endmodule

// File: tb/tb_io_port_bank.sv
// Self-checking bench for io_port_bank: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model of the port rules.
module tb_io_port_bank;

  localparam logic [3:0] TB_RD_MASK = 4'b1001;
`ifdef IO_READBACK_EN
  localparam logic [3:0] TB_RB_MASK = 4'b1000;
`else
  localparam logic [3:0] TB_RB_MASK = 4'b0000;
`endif

  logic        clk28 = 1'b0;
  logic        rst_n;
  logic        clkcpu_ck;
  logic [3:0]  en;
  logic        unlock;
  logic [31:0] rd_src;
  logic [31:0] port_q;
  logic [3:0]  wstb;
  logic        locked;
  logic [7:0]  d_out;
  logic        d_out_active;

  cpu_bus bus_if ();

  io_port_bank #(
    .RD_MASK (TB_RD_MASK)
`ifdef IO_READBACK_EN
    ,
    .RB_MASK (TB_RB_MASK)
`endif
  ) dut (
    .clk28        (clk28),
    .rst_n        (rst_n),
    .bus          (bus_if),
    .clkcpu_ck    (clkcpu_ck),
    .en           (en),
    .unlock       (unlock),
    .rd_src       (rd_src),
    .port_q       (port_q),
    .wstb         (wstb),
    .locked       (locked),
    .d_out        (d_out),
    .d_out_active (d_out_active)
  );

  always #5 clk28 = ~clk28;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model ----------------
  logic [15:0] m_match [4] = '{16'h00FE, 16'h7FFD, 16'h1FFD, 16'hDFFD};
  logic [15:0] m_mask  [4] = '{16'h0001, 16'h8002, 16'hFFFF, 16'hFFFF};
  logic [3:0]  m_sync = 4'b0001;
  logic [3:0]  m_lockm = 4'b0010;
  logic [7:0]  m_q [4];
  logic [3:0]  m_wstb;
  logic [3:0]  m_served;
  logic [3:0]  m_rd;

  function automatic bit hits(int i);
    return en[i] && bus_if.ioreq && (((bus_if.a_reg ^ m_match[i]) & m_mask[i]) == 16'h0);
  endfunction

  task automatic model_step();
    bit is_locked;
    bit hit, can;
    is_locked = m_q[1][5];
    for (int i = 0; i < 4; i++) begin
      if (!rst_n) begin
        m_q[i] = 8'h00; m_wstb[i] = 1'b0; m_served[i] = 1'b0; m_rd[i] = 1'b0;
      end else begin
        hit = hits(i);
        can = hit && bus_if.wr && !(m_lockm[i] && is_locked && !unlock)
              && !m_served[i] && (!m_sync[i] || clkcpu_ck);
        if (can) m_q[i] = bus_if.d_reg;
        m_wstb[i]   = can;
        m_served[i] = (hit && bus_if.wr) ? (m_served[i] || can) : 1'b0;
        m_rd[i]     = hit && bus_if.rd && TB_RD_MASK[i];
      end
    end
  endtask

  function automatic logic [7:0] model_dout();
    for (int i = 0; i < 4; i++)
      if (m_rd[i]) return TB_RB_MASK[i] ? m_q[i] : rd_src[i*8 +: 8];
    return 8'hFF;
  endfunction

  function automatic logic [31:0] model_port_q();
    return {m_q[3], m_q[2], m_q[1], m_q[0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_step();
    @(posedge clk28);
    #1;
  endtask

  task automatic bus_idle();
    bus_if.ioreq = 1'b0; bus_if.rd = 1'b0; bus_if.wr = 1'b0;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d, input int cycles);
    bus_if.ioreq = 1'b1; bus_if.wr = 1'b1; bus_if.rd = 1'b0;
    bus_if.a_reg = a; bus_if.d_reg = d;
    repeat (cycles) tick();
    bus_idle();
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int pulses;
    rst_n = 1'b0;
    bus_if.ioreq = 1'b1; bus_if.wr = 1'b1; bus_if.rd = 1'b0;
    bus_if.a_reg = 16'h7FFD; bus_if.d_reg = 8'h17;
    repeat (3) begin
      tick();
      n_checks++;
      if (port_q !== 32'h0) $display("FAIL reset_port_q: got %h expected %h", port_q, 32'h0);
      else n_pass++;
      n_checks++;
      if (wstb !== 4'h0) $display("FAIL reset_wstb: got %b expected %b", wstb, 4'h0);
      else n_pass++;
      n_checks++;
      if (d_out_active !== 1'b0 || d_out !== 8'hFF)
        $display("FAIL reset_read: got %b/%h expected 0/ff", d_out_active, d_out);
      else n_pass++;
    end
    rst_n = 1'b1;
    pulses = 0;
    repeat (4) begin
      tick();
      pulses += int'(wstb[1]);
    end
    n_checks++;
    if (pulses != 1) $display("FAIL reset_release_pulses: got %0d expected 1", pulses);
    else n_pass++;
    n_checks++;
    if (port_q[15:8] !== 8'h17) $display("FAIL reset_release_q1: got %h expected 17", port_q[15:8]);
    else n_pass++;
    bus_idle();
    tick();
  endtask

  task automatic test_sync_write();
    bus_if.ioreq = 1'b1; bus_if.wr = 1'b1; bus_if.rd = 1'b0;
    bus_if.a_reg = 16'h00FE; bus_if.d_reg = 8'h15;
    for (int k = 1; k <= 8; k++) begin
      clkcpu_ck = (k == 5);
      tick();
      n_checks++;
      if (wstb[0] !== (k == 5)) $display("FAIL sync_wstb0 cycle %0d: got %b expected %b", k, wstb[0], k == 5);
      else n_pass++;
      n_checks++;
      if (port_q[7:0] !== ((k >= 5) ? 8'h15 : 8'h00))
        $display("FAIL sync_q0 cycle %0d: got %h expected %h", k, port_q[7:0], (k >= 5) ? 8'h15 : 8'h00);
      else n_pass++;
    end
    clkcpu_ck = 1'b0;
    bus_idle();
    tick();
  endtask

  task automatic test_lock();
    bus_write(16'h7FFD, 8'h20, 2);
    n_checks++;
    if (locked !== 1'b1 || port_q[15:8] !== 8'h20)
      $display("FAIL lock_set: got %b/%h expected 1/20", locked, port_q[15:8]);
    else n_pass++;
    bus_if.ioreq = 1'b1; bus_if.wr = 1'b1; bus_if.a_reg = 16'h7FFD; bus_if.d_reg = 8'h03;
    repeat (3) tick();
    n_checks++;
    if (port_q[15:8] !== 8'h20 || wstb[1] !== 1'b0)
      $display("FAIL lock_blocked: got %h/%b expected 20/0", port_q[15:8], wstb[1]);
    else n_pass++;
    unlock = 1'b1;
    tick();
    n_checks++;
    if (port_q[15:8] !== 8'h03 || wstb[1] !== 1'b1)
      $display("FAIL lock_unlock_commit: got %h/%b expected 03/1", port_q[15:8], wstb[1]);
    else n_pass++;
    n_checks++;
    if (locked !== 1'b0) $display("FAIL lock_cleared: got %b expected 0", locked);
    else n_pass++;
    tick();
    n_checks++;
    if (wstb[1] !== 1'b0) $display("FAIL lock_single_commit: got %b expected 0", wstb[1]);
    else n_pass++;
    unlock = 1'b0;
    bus_idle();
    tick();
  endtask

  task automatic test_lock_bypass();
    bus_write(16'h7FFD, 8'h20, 2);
    bus_write(16'h1FFD, 8'h05, 2);
    n_checks++;
    if (port_q[23:16] !== 8'h05) $display("FAIL bypass_q2: got %h expected 05", port_q[23:16]);
    else n_pass++;
    n_checks++;
    if (port_q[15:8] !== 8'h20 || locked !== 1'b1)
      $display("FAIL bypass_q1_held: got %h/%b expected 20/1", port_q[15:8], locked);
    else n_pass++;
  endtask

  task automatic test_read();
    rd_src = {8'hC3, 8'h11, 8'h22, 8'hBF};
    bus_if.ioreq = 1'b1; bus_if.rd = 1'b1; bus_if.wr = 1'b0; bus_if.a_reg = 16'h00FE;
    #1;
    n_checks++;
    if (d_out_active !== 1'b0) $display("FAIL read_latency: got %b expected 0", d_out_active);
    else n_pass++;
    tick();
    n_checks++;
    if (d_out_active !== 1'b1 || d_out !== 8'hBF)
      $display("FAIL read_fe: got %b/%h expected 1/bf", d_out_active, d_out);
    else n_pass++;
    bus_if.a_reg = 16'h00FF;
    tick();
    n_checks++;
    if (d_out_active !== 1'b0 || d_out !== 8'hFF)
      $display("FAIL read_miss: got %b/%h expected 0/ff", d_out_active, d_out);
    else n_pass++;
    bus_idle();
    tick();
  endtask

  task automatic test_readback();
    logic [7:0] exp_d;
    rd_src = {8'hC3, 8'h11, 8'h22, 8'hBF};
    bus_write(16'hDFFD, 8'h1A, 2);
    bus_if.ioreq = 1'b1; bus_if.rd = 1'b1; bus_if.a_reg = 16'hDFFD;
    tick();
    exp_d = (TB_RB_MASK[3]) ? 8'h1A : 8'hC3;
    n_checks++;
    if (d_out_active !== 1'b1 || d_out !== exp_d)
      $display("FAIL readback_dffd: got %b/%h expected 1/%h", d_out_active, d_out, exp_d);
    else n_pass++;
    bus_idle();
    tick();
  endtask

  task automatic test_random();
    logic [15:0] addrs [6] = '{16'h00FE, 16'h7FFD, 16'h1FFD, 16'hDFFD, 16'h00FF, 16'h3FFC};
    for (int c = 0; c < 400; c++) begin
      rst_n     = ($urandom_range(0, 39) != 0);
      clkcpu_ck = $urandom_range(0, 1);
      unlock    = ($urandom_range(0, 7) == 0);
      en        = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      rd_src    = $urandom;
      if ($urandom_range(0, 2) == 0) begin
        bus_if.ioreq = ($urandom_range(0, 3) != 0);
        bus_if.wr    = $urandom_range(0, 1);
        bus_if.rd    = !bus_if.wr && $urandom_range(0, 1);
        bus_if.a_reg = (c % 10 == 9) ? 16'($urandom) : addrs[$urandom_range(0, 5)];
        bus_if.d_reg = 8'($urandom);
      end
      tick();
      n_checks++;
      if (port_q !== model_port_q()) $display("FAIL rand_port_q cyc %0d: got %h expected %h", c, port_q, model_port_q());
      else n_pass++;
      n_checks++;
      if (wstb !== m_wstb) $display("FAIL rand_wstb cyc %0d: got %b expected %b", c, wstb, m_wstb);
      else n_pass++;
      n_checks++;
      if (locked !== m_q[1][5]) $display("FAIL rand_locked cyc %0d: got %b expected %b", c, locked, m_q[1][5]);
      else n_pass++;
      n_checks++;
      if (d_out_active !== (|m_rd)) $display("FAIL rand_active cyc %0d: got %b expected %b", c, d_out_active, |m_rd);
      else n_pass++;
      n_checks++;
      if (d_out !== model_dout()) $display("FAIL rand_dout cyc %0d: got %h expected %h", c, d_out, model_dout());
      else n_pass++;
    end
    rst_n = 1'b1; unlock = 1'b0; bus_idle();
    tick();
  endtask

  initial begin
    rst_n = 1'b0; clkcpu_ck = 1'b0; en = 4'hF; unlock = 1'b0; rd_src = '0;
    bus_idle(); bus_if.a_reg = '0; bus_if.d_reg = '0;
    for (int i = 0; i < 4; i++) m_q[i] = 8'h00;
    m_wstb = '0; m_served = '0; m_rd = '0;
    test_reset();
    test_sync_write();
    test_lock();
    test_lock_bypass();
    test_read();
    test_readback();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
